csr_rmw_stage: RTL

- Upstream issue stage for the per-core CSR data store.
- Accepts CSR instructions from the dispatch/issue path and drives the store's read and write ports. Performs RISC-V read-modify-write semantics (CSRRW/CSRRS/CSRRC and immediate forms).
- Returns the old CSR value to writeback through a two-entry valid/ready pipeline.
- Stalls FP CSR accesses while FP ops of the same warp are in flight.

---
 rtl/csr_rmw_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_rmw_stage.sv
// rtl/csr_rmw_stage.sv - CSR read-modify-write issue stage feeding the per-core CSR store
//
// Purpose: accepts CSR instructions, reads the store combinationally from S1,
// computes the RISC-V RW/RS/RC write value, writes it back when S1 fires and
// returns the pre-write CSR value to writeback through S2.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_*                      issue-side request (valid/ready)
//   fpu_pending                per-warp FP-op-in-flight flags
//   read_*, read_data          store read port (read_data is combinational)
//   write_*                    store write port
//   rsp_*                      writeback response (valid/ready), old value on all lanes
//   busy                       either stage occupied

`ifndef UUID_BITS
`define UUID_BITS 16
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

module csr_rmw_stage #(
  parameter int CORE_ID     = 0,
  parameter int NUM_WARPS   = `NUM_WARPS,
  parameter int NUM_THREADS = `NUM_THREADS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [`UUID_BITS-1:0]         req_uuid,
  input  logic [`NW_BITS-1:0]           req_wid,
  input  logic [NUM_THREADS-1:0]        req_tmask,
  input  logic [31:0]                   req_pc,
  input  logic [`NR_BITS-1:0]           req_rd,
  input  logic                          req_wb,
  input  logic [1:0]                    req_op,
  input  logic                          req_use_imm,
  input  logic [4:0]                    req_imm,
  input  logic                          req_rs1_is_x0,
  input  logic [31:0]                   req_rs1_data,
  input  logic [`CSR_ADDR_BITS-1:0]     req_addr,
  input  logic [NUM_WARPS-1:0]          fpu_pending,
  output logic                          read_enable,
  output logic [`UUID_BITS-1:0]         read_uuid,
  output logic [`CSR_ADDR_BITS-1:0]     read_addr,
  output logic [`NW_BITS-1:0]           read_wid,
  input  logic [31:0]                   read_data,
  output logic                          write_enable,
  output logic [`UUID_BITS-1:0]         write_uuid,
  output logic [`CSR_ADDR_BITS-1:0]     write_addr,
  output logic [`NW_BITS-1:0]           write_wid,
  output logic [31:0]                   write_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`UUID_BITS-1:0]         rsp_uuid,
  output logic [`NW_BITS-1:0]           rsp_wid,
  output logic [NUM_THREADS-1:0]        rsp_tmask,
  output logic [31:0]                   rsp_pc,
  output logic [`NR_BITS-1:0]           rsp_rd,
  output logic                          rsp_wb,
  output logic [NUM_THREADS*32-1:0]     rsp_data,
  output logic                          busy
);

  localparam logic [`CSR_ADDR_BITS-1:0] CSR_FFLAGS = `CSR_ADDR_BITS'h001;
  localparam logic [`CSR_ADDR_BITS-1:0] CSR_FRM    = `CSR_ADDR_BITS'h002;
  localparam logic [`CSR_ADDR_BITS-1:0] CSR_FCSR   = `CSR_ADDR_BITS'h003;
  localparam logic [1:0] OP_RS = 2'd2;
  localparam logic [1:0] OP_RC = 2'd3;
  localparam logic [1:0] OP_RW = 2'd1;

  // S1: accepted request
  logic                      r_s1_valid;
  logic [`UUID_BITS-1:0]     r_s1_uuid;
  logic [`NW_BITS-1:0]       r_s1_wid;
  logic [NUM_THREADS-1:0]    r_s1_tmask;
  logic [31:0]               r_s1_pc;
  logic [`NR_BITS-1:0]       r_s1_rd;
  logic                      r_s1_wb;
  logic [1:0]                r_s1_op;
  logic [31:0]               r_s1_src;
  logic                      r_s1_write_req;
  logic [`CSR_ADDR_BITS-1:0] r_s1_addr;

  // S2: response
  logic                      r_s2_valid;
  logic [`UUID_BITS-1:0]     r_s2_uuid;
  logic [`NW_BITS-1:0]       r_s2_wid;
  logic [NUM_THREADS-1:0]    r_s2_tmask;
  logic [31:0]               r_s2_pc;
  logic [`NR_BITS-1:0]       r_s2_rd;
  logic                      r_s2_wb;
  logic [31:0]               r_s2_data;

  logic        w_fp_addr;
  logic        w_fp_stall;
  logic        w_fire;
  logic        w_accept;
  logic [31:0] w_src;
  logic        w_src_zero;
  logic [31:0] w_wdata;

  assign w_src      = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
  // RS/RC suppress the write based on the source field being x0/zero,
  // not on the operand value (an rs1 holding 0 still writes).
  assign w_src_zero = req_use_imm ? (req_imm == 5'd0) : req_rs1_is_x0;

  assign w_fp_addr  = (r_s1_addr == CSR_FFLAGS) || (r_s1_addr == CSR_FRM) ||
                      (r_s1_addr == CSR_FCSR);
  assign w_fp_stall = r_s1_valid && fpu_pending[r_s1_wid] && w_fp_addr;
  assign w_fire     = r_s1_valid && !w_fp_stall && (!r_s2_valid || rsp_ready);
  assign req_ready  = !r_s1_valid || w_fire;
  assign w_accept   = req_valid && req_ready;

  always_comb begin
    w_wdata = r_s1_src;
    case (r_s1_op)
      OP_RS:   w_wdata = read_data | r_s1_src;
      OP_RC:   w_wdata = read_data & ~r_s1_src;
      default: w_wdata = r_s1_src;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_accept)
        r_s1_valid <= 1'b1;
      else if (w_fire)
        r_s1_valid <= 1'b0;

      if (w_fire)
        r_s2_valid <= 1'b1;
      else if (rsp_ready)
        r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_uuid      <= req_uuid;
      r_s1_wid       <= req_wid;
      r_s1_tmask     <= req_tmask;
      r_s1_pc        <= req_pc;
      r_s1_rd        <= req_rd;
      r_s1_wb        <= req_wb;
      r_s1_op        <= req_op;
      r_s1_src       <= w_src;
      r_s1_write_req <= (req_op == OP_RW) || !w_src_zero;
      r_s1_addr      <= req_addr;
    end
    if (w_fire) begin
      r_s2_uuid  <= r_s1_uuid;
      r_s2_wid   <= r_s1_wid;
      r_s2_tmask <= r_s1_tmask;
      r_s2_pc    <= r_s1_pc;
      r_s2_rd    <= r_s1_rd;
      r_s2_wb    <= r_s1_wb;
      r_s2_data  <= read_data;
    end
  end

  assign read_enable  = r_s1_valid;
  assign read_uuid    = r_s1_uuid;
  assign read_addr    = r_s1_addr;
  assign read_wid     = r_s1_wid;

  assign write_enable = w_fire && r_s1_write_req;
  assign write_uuid   = r_s1_uuid;
  assign write_addr   = r_s1_addr;
  assign write_wid    = r_s1_wid;
  assign write_data   = w_wdata;

  assign rsp_valid    = r_s2_valid;
  assign rsp_uuid     = r_s2_uuid;
  assign rsp_wid      = r_s2_wid;
  assign rsp_tmask    = r_s2_tmask;
  assign rsp_pc       = r_s2_pc;
  assign rsp_rd       = r_s2_rd;
  assign rsp_wb       = r_s2_wb;
  assign rsp_data     = {NUM_THREADS{r_s2_data}};

  assign busy         = r_s1_valid | r_s2_valid;

  a_op_legal: assert property (@(posedge clk) disable iff (reset)
                               w_accept |-> (req_op != 2'd0))
    else $error("csr_rmw_stage core %0d: illegal CSR op 0 accepted", CORE_ID);

endmodule
